// File: rtl/frame_controller_pkg.sv
// Shared definitions for the serial packet router control path: state encoding
// and field-length defaults used by both the controller and the datapath.
package frame_controller_pkg;

  localparam int ADDR_BITS_DEF = 6;
  localparam int SIZE_BITS_DEF = 6;
  localparam int CNT_W_DEF     = 8;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ADDR   = 3'd1,
    SIZE   = 3'd2,
    STREAM = 3'd3,
    DONE   = 3'd4
  } fc_state_t;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/frame_controller_bit_counter.sv
// Phase bit counter: clear has priority over enable; reset clears to zero.
module bit_counter #(
  parameter int W = 6
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] count
);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      count <= '0;
    end else if (en) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/frame_controller.sv
// Frame control FSM: start bit, address shift, size shift, payload stream,
// done pulse. Enables are registered from the next state; the send strobe
// is decoded live because size_chunk only settles on the SIZE-to-STREAM edge.
module frame_controller
  import frame_controller_pkg::*;
#(
  parameter int ADDR_BITS = ADDR_BITS_DEF,
  parameter int SIZE_BITS = SIZE_BITS_DEF,
  parameter int CNT_W     = CNT_W_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 serIn,
  input  logic [SIZE_BITS-1:0] size_chunk,
  output logic                 Sreg1_en,
  output logic                 Sreg2_en,
  output logic                 send_to_smbs,
  output logic                 busy,
  output logic                 done,
  output logic [CNT_W-1:0]     frame_cnt,
  output logic [2:0]           state_dbg
);

  localparam int BC_W = max_int($clog2(ADDR_BITS), SIZE_BITS);

  fc_state_t         state, state_n;
  logic [BC_W-1:0]   cnt;
  logic [BC_W:0]     cnt_inc;
  logic [BC_W:0]     size_ext;
  logic              cnt_clr, cnt_en;
  logic              addr_last, size_last, stream_last;

  bit_counter #(.W(BC_W)) u_bit_counter (
    .clk   (clk),
    .rst   (rst),
    .clr   (cnt_clr),
    .en    (cnt_en),
    .count (cnt)
  );

  assign cnt_inc     = {1'b0, cnt} + (BC_W+1)'(1);
  assign size_ext    = (BC_W+1)'(size_chunk);
  assign addr_last   = (cnt == BC_W'(ADDR_BITS - 1));
  assign size_last   = (cnt == BC_W'(SIZE_BITS - 1));
  // A zero-length payload still spends one cycle in STREAM, with no strobe.
  assign stream_last = (size_chunk == '0) || (cnt_inc == size_ext);

  assign send_to_smbs = (state == STREAM) && ({1'b0, cnt} != size_ext);
  assign state_dbg    = state;

  always_comb begin
    state_n = state;
    cnt_clr = 1'b0;
    cnt_en  = 1'b0;
    case (state)
      IDLE: begin
        cnt_clr = 1'b1;
        if (!serIn) state_n = ADDR;
      end
      ADDR: begin
        if (addr_last) begin
          state_n = SIZE;
          cnt_clr = 1'b1;
        end else begin
          cnt_en = 1'b1;
        end
      end
      SIZE: begin
        if (size_last) begin
          state_n = STREAM;
          cnt_clr = 1'b1;
        end else begin
          cnt_en = 1'b1;
        end
      end
      STREAM: begin
        if (stream_last) begin
          state_n = DONE;
          cnt_clr = 1'b1;
        end else begin
          cnt_en = 1'b1;
        end
      end
      DONE: begin
        state_n = IDLE;
        cnt_clr = 1'b1;
      end
      default: begin
        state_n = IDLE;
        cnt_clr = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      Sreg1_en  <= 1'b0;
      Sreg2_en  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      frame_cnt <= '0;
    end else begin
      state    <= state_n;
      Sreg1_en <= (state_n == ADDR);
      Sreg2_en <= (state_n == SIZE);
      busy     <= (state_n != IDLE);
      done     <= (state_n == DONE);
      if (state == DONE) frame_cnt <= frame_cnt + CNT_W'(1);
    end
  end

endmodule
